// File: rtl/pair_match_resolver_if.sv
// Tile-select handshake from the switch decoder to the pair resolver.
interface pair_match_resolver_if;
  logic       sel_valid;
  logic [3:0] sel_idx;
  logic       sel_ready;

  modport master (output sel_valid, output sel_idx, input sel_ready);
  modport slave  (input sel_valid, input sel_idx, output sel_ready);
endinterface

// File: rtl/pair_match_resolver.sv
// Holds the first tile pick, blinks both picks, then keeps matched pairs lit or clears misses.
// state   | meaning
// IDLE    | waiting for first pick
// ONE     | first pick held, waiting for second
// BLINK   | both picks blinking, picks refused
// RESOLVE | one cycle: colour compare, mask/LED update, pulse
// DONE    | every tile matched, waits for clear
module pair_match_resolver #(
  parameter int                    NUM_TILES     = 10,
  parameter int                    BLINK_CYCLES  = 25_000_000,
  parameter int                    BLINK_TOGGLES = 4,
  parameter logic [3*NUM_TILES-1:0] COLOR_MAP    = 30'b101_101_001_011_100_010_100_011_010_001
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 game_clear,
  pair_match_resolver_if.slave sel,
  output logic [NUM_TILES-1:0] LEDR,
  output logic [NUM_TILES-1:0] matched_mask,
  output logic [7:0]           moves,
  output logic                 match_pulse,
  output logic                 miss_pulse,
  output logic                 all_matched
);

  localparam int TW  = $clog2(BLINK_CYCLES + 1);
  localparam int TCW = $clog2(BLINK_TOGGLES + 1);
  localparam logic [TW-1:0]        RELOAD = TW'(BLINK_CYCLES - 1);
  localparam logic [TCW-1:0]       TOG_LAST = TCW'(BLINK_TOGGLES);
  localparam logic [NUM_TILES-1:0] BIT0 = NUM_TILES'(1);

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_BLINK, S_RESOLVE, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [3:0]           first_idx, first_nxt, second_idx, second_nxt;
  logic [NUM_TILES-1:0] mask_q, mask_nxt, ledr_q, ledr_nxt;
  logic [7:0]           moves_q, moves_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [TCW-1:0]       tog_cnt, tog_nxt;
  logic                 phase, phase_nxt;
  logic                 match_q, match_nxt, miss_q, miss_nxt;

  logic                 pick, pick_ok;
  logic [NUM_TILES-1:0] pick_oh, pair_oh;

  function automatic logic [2:0] color_of(input logic [3:0] idx);
    return 3'(COLOR_MAP >> (3 * int'(idx)));
  endfunction

  assign sel.sel_ready = (state == S_IDLE) || (state == S_ONE);
  assign pick          = sel.sel_valid && sel.sel_ready;
  // Shifting past the top bit yields zero, so out-of-range indices never alias a tile.
  assign pick_oh       = BIT0 << sel.sel_idx;
  assign pick_ok       = (int'(sel.sel_idx) < NUM_TILES) && ((pick_oh & mask_q) == '0);
  assign pair_oh       = (BIT0 << first_idx) | (BIT0 << second_idx);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn || game_clear) begin
      state      <= S_IDLE;
      first_idx  <= '0;
      second_idx <= '0;
      mask_q     <= '0;
      ledr_q     <= '0;
      moves_q    <= '0;
      timer      <= '0;
      tog_cnt    <= '0;
      phase      <= 1'b0;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_idx  <= first_nxt;
      second_idx <= second_nxt;
      mask_q     <= mask_nxt;
      ledr_q     <= ledr_nxt;
      moves_q    <= moves_nxt;
      timer      <= timer_nxt;
      tog_cnt    <= tog_nxt;
      phase      <= phase_nxt;
      match_q    <= match_nxt;
      miss_q     <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    first_nxt  = first_idx;
    second_nxt = second_idx;
    mask_nxt   = mask_q;
    ledr_nxt   = ledr_q;
    moves_nxt  = moves_q;
    timer_nxt  = timer;
    tog_nxt    = tog_cnt;
    phase_nxt  = phase;
    match_nxt  = 1'b0;
    miss_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick && pick_ok) begin
          first_nxt = sel.sel_idx;
          ledr_nxt  = ledr_q | pick_oh;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (pick && pick_ok && (sel.sel_idx != first_idx)) begin
          second_nxt = sel.sel_idx;
          ledr_nxt   = ledr_q | pick_oh;
          moves_nxt  = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          timer_nxt  = RELOAD;
          tog_nxt    = '0;
          phase_nxt  = 1'b1;
          state_nxt  = S_BLINK;
        end
      end
      S_BLINK: begin
        if (timer == '0) begin
          phase_nxt = ~phase;
          tog_nxt   = tog_cnt + 1'b1;
          timer_nxt = RELOAD;
          if (tog_nxt == TOG_LAST) state_nxt = S_RESOLVE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
        ledr_nxt = (mask_q & ~pair_oh) | (phase_nxt ? pair_oh : '0);
      end
      S_RESOLVE: begin
        if (color_of(first_idx) == color_of(second_idx)) begin
          mask_nxt  = mask_q | pair_oh;
          match_nxt = 1'b1;
        end else begin
          miss_nxt  = 1'b1;
        end
        ledr_nxt  = mask_nxt;
        state_nxt = (&mask_nxt) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        ledr_nxt = '1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign LEDR         = ledr_q;
  assign matched_mask = mask_q;
  assign moves        = moves_q;
  assign match_pulse  = match_q;
  assign miss_pulse   = miss_q;
  assign all_matched  = (state == S_DONE);

endmodule
